// File: rtl/helicopter_pkg.sv
// Shared constants and types for the helicopter game's VGA drawing path.
package helicopter_pkg;

    // Screen geometry and pixel-write bus widths.
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;

    // 3-bit RGB colours used by the game.
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] BLACK = 3'b000;

    // Rectangle plotter control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rect_scan.sv
// Column-major scan counter for the rectangle plotter: walks cy down each
// column, then steps cx, and reports which edge of the rectangle it is on.
module rect_scan #(
    parameter int WW = 5,
    parameter int HW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          step,
    input  logic [WW-1:0] w,
    input  logic [HW-1:0] h,
    output logic [WW-1:0] cx,
    output logic [HW-1:0] cy,
    output logic          first_col,
    output logic          last_col,
    output logic          first_row,
    output logic          last_row,
    output logic          last
);

    // Advance one pixel per step: row first, then wrap to the next column.
    always_ff @(posedge clock) begin
        // NOTE: registers are written with <= so every flop samples the
        // pre-edge value of its neighbours, independent of statement order.
        if (reset || clear) begin
            cx <= '0;
            cy <= '0;
        end else if (step) begin
            if (last_row) begin
                cy <= '0;
                cx <= cx + WW'(1);
            end else begin
                cy <= cy + HW'(1);
            end
        end
    end

    // Edge flags drive the border colour; last marks the final pixel.
    assign first_col = (cx == '0);
    assign last_col  = (cx == w - WW'(1));
    assign first_row = (cy == '0);
    assign last_row  = (cy == h - HW'(1));
    assign last      = last_col && last_row;

endmodule

// File: rtl/draw_rect.sv
// Configurable rectangle plotter: latches a rectangle on start and emits one
// registered pixel write per clock, column-major, with border/fill/erase
// colouring and clipping of off-screen pixels.
module draw_rect #(
    parameter int             X_W      = helicopter_pkg::X_W,
    parameter int             Y_W      = helicopter_pkg::Y_W,
    parameter int             C_W      = helicopter_pkg::C_W,
    parameter int             MAX_W    = 16,
    parameter int             MAX_H    = 16,
    parameter int             SCREEN_W = helicopter_pkg::SCREEN_W,
    parameter int             SCREEN_H = helicopter_pkg::SCREEN_H,
    parameter logic [C_W-1:0] BG_COLOR = '0,
    localparam int            WW       = $clog2(MAX_W) + 1,
    localparam int            HW       = $clog2(MAX_H) + 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [WW-1:0]  w,
    input  logic [HW-1:0]  h,
    input  logic [C_W-1:0] fill_color,
    input  logic [C_W-1:0] border_color,
    input  logic           erase,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic [C_W-1:0] color,
    output logic           en,
    output logic           busy,
    output logic           done
);

    import helicopter_pkg::*;

    state_t state, state_nxt;

    logic [X_W-1:0] x_l;
    logic [Y_W-1:0] y_l;
    logic [WW-1:0]  w_l;
    logic [HW-1:0]  h_l;
    logic [C_W-1:0] fill_l;
    logic [C_W-1:0] border_l;
    logic           erase_l;

    logic           load;
    logic           step;

    logic [WW-1:0]  cx;
    logic [HW-1:0]  cy;
    logic           first_col, last_col, first_row, last_row, last;

    logic [X_W:0]   sum_x;
    logic [Y_W:0]   sum_y;
    logic           visible;
    logic           on_edge;
    logic [C_W-1:0] pix_color;

    rect_scan #(
        .WW (WW),
        .HW (HW)
    ) u_scan (
        .clock     (clock),
        .reset     (reset),
        .clear     (load),
        .step      (step),
        .w         (w_l),
        .h         (h_l),
        .cx        (cx),
        .cy        (cy),
        .first_col (first_col),
        .last_col  (last_col),
        .first_row (first_row),
        .last_row  (last_row),
        .last      (last)
    );

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = (w == '0 || h == '0) ? DONE : DRAW;
                end
            end
            DRAW: begin
                step = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Capture the request; oversize dimensions are clamped to the maximum.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_l      <= '0;
            y_l      <= '0;
            w_l      <= '0;
            h_l      <= '0;
            fill_l   <= '0;
            border_l <= '0;
            erase_l  <= 1'b0;
        end else if (load) begin
            x_l      <= x;
            y_l      <= y;
            w_l      <= (w > WW'(MAX_W)) ? WW'(MAX_W) : w;
            h_l      <= (h > HW'(MAX_H)) ? HW'(MAX_H) : h;
            fill_l   <= fill_color;
            border_l <= border_color;
            erase_l  <= erase;
        end
    end

    // Pixel address one bit wide so coordinates past the screen are caught
    // rather than wrapping back onto it.
    assign sum_x   = {1'b0, x_l} + (X_W+1)'(cx);
    assign sum_y   = {1'b0, y_l} + (Y_W+1)'(cy);
    assign visible = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));

    // Colour select: erase wins, then border on any outer row/column.
    assign on_edge   = first_col || last_col || first_row || last_row;
    assign pix_color = erase_l ? BG_COLOR : (on_edge ? border_l : fill_l);

    // Registered pixel bus; address/colour hold outside DRAW.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_x <= '0;
            out_y <= '0;
            color <= '0;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            en   <= 1'b0;
            busy <= 1'b0;
            done <= (state == DONE);
            if (state == DRAW) begin
                out_x <= sum_x[X_W-1:0];
                out_y <= sum_y[Y_W-1:0];
                color <= pix_color;
                en    <= visible;
                busy  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_draw_rect.sv
// Directed bench for draw_rect: each rectangle is checked pixel by pixel
// against coordinates and colours computed from the request.
module tb_draw_rect;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] x;
    logic [6:0] y;
    logic [4:0] w;
    logic [4:0] h;
    logic [2:0] fill_color;
    logic [2:0] border_color;
    logic       erase;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] color;
    logic       en;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] C_RED   = 3'b100;
    localparam logic [2:0] C_WHITE = 3'b111;
    localparam logic [2:0] C_GREEN = 3'b010;

    draw_rect dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .x            (x),
        .y            (y),
        .w            (w),
        .h            (h),
        .fill_color   (fill_color),
        .border_color (border_color),
        .erase        (erase),
        .out_x        (out_x),
        .out_y        (out_y),
        .color        (color),
        .en           (en),
        .busy         (busy),
        .done         (done)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Idle for n cycles, expecting no plot strobe and no done.
    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            check("idle_en", en, 0);
            check("idle_done", done, 0);
        end
    endtask

    // Issue one rectangle and check every presented pixel.
    // poke_at: pixel index after which a stray start is pulsed (-1 = none).
    // abort_at: pixel index after which reset is asserted (-1 = none).
    task automatic run_rect(input int rx, input int ry, input int rw, input int rh,
                            input logic [2:0] fc, input logic [2:0] bc, input logic er,
                            input int poke_at, input int abort_at, input int exp_pix);
        int mw, mh, total, npix, cx, cy, ax, ay;
        logic vis;
        logic [2:0] ecol;
        bit aborted;
        mw = (rw > 16) ? 16 : rw;
        mh = (rh > 16) ? 16 : rh;
        total = mw * mh;
        npix = 0;
        aborted = 0;
        x = rx[7:0]; y = ry[6:0]; w = rw[4:0]; h = rh[4:0];
        fill_color = fc; border_color = bc; erase = er;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        // Scramble inputs so a design that fails to latch shows up.
        x = 8'd77; y = 7'd33; w = 5'd1; h = 5'd1;
        fill_color = 3'b011; border_color = 3'b001; erase = ~er;
        for (int k = 0; k < total; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
            cx = k / mh;
            cy = k % mh;
            ax = rx + cx;
            ay = ry + cy;
            vis = (ax < 160) && (ay < 120);
            if (er) ecol = 3'b000;
            else if (cx == 0 || cx == mw - 1 || cy == 0 || cy == mh - 1) ecol = bc;
            else ecol = fc;
            check("busy", busy, 1);
            check("en", en, vis);
            check("done_early", done, 0);
            check("out_x", out_x, ax & 255);
            check("out_y", out_y, ay & 127);
            check("color", color, ecol);
            if (en) npix++;
            if (k == poke_at) begin
                start = 1'b1;
                x = 8'd1; y = 7'd1; w = 5'd1; h = 5'd1;
            end
            if (k == abort_at) begin
                reset = 1'b1;
                @(posedge clock); #1;
                reset = 1'b0;
                check("rst_en", en, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_out_x", out_x, 0);
                check("rst_out_y", out_y, 0);
                check("rst_color", color, 0);
                aborted = 1;
                break;
            end
        end
        if (!aborted) begin
            @(posedge clock); #1;
            start = 1'b0;
            check("done", done, 1);
            check("done_en", en, 0);
            check("done_busy", busy, 0);
            check("npix", npix, exp_pix);
            @(posedge clock); #1;
            check("done_once", done, 0);
            check("idle_en", en, 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        x = '0; y = '0; w = '0; h = '0;
        fill_color = '0; border_color = '0; erase = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_en", en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_out_x", out_x, 0);
        check("reset_out_y", out_y, 0);
        check("reset_color", color, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // 3x4 border/fill rectangle, then the same area erased.
        run_rect(10, 20, 3, 4, C_RED, C_WHITE, 1'b0, -1, -1, 12);
        run_rect(10, 20, 3, 4, C_RED, C_WHITE, 1'b1, -1, -1, 12);
        // Bottom-right corner: only a 2x2 corner is on screen.
        run_rect(158, 118, 4, 4, C_RED, C_WHITE, 1'b0, -1, -1, 4);
        // Zero width completes immediately with no pixels.
        run_rect(30, 40, 0, 5, C_RED, C_WHITE, 1'b0, -1, -1, 0);
        // Stray start mid-draw is dropped, not queued.
        run_rect(50, 60, 2, 2, C_GREEN, C_WHITE, 1'b0, 1, -1, 4);
        idle_check(4);
        // Start in IDLE is accepted afterwards.
        run_rect(70, 10, 3, 3, C_GREEN, C_RED, 1'b0, -1, -1, 9);
        // Reset after the third pixel aborts with no done.
        run_rect(5, 6, 4, 4, C_RED, C_WHITE, 1'b0, -1, 2, 0);
        idle_check(3);
        run_rect(5, 6, 4, 4, C_RED, C_WHITE, 1'b0, -1, -1, 16);
        // Oversize width clamps to 16; single row is all border.
        run_rect(0, 0, 20, 1, C_RED, C_WHITE, 1'b0, -1, -1, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
